// File: rtl/i2c_reg_sequencer_if.sv
// Command/response link between the register sequencer (master) and the I2C byte engine (slave).
interface i2c_reg_sequencer_if;
  logic [1:0] i2cInstruction;
  logic [7:0] i2cByteToSend;
  logic       i2cEnable;
  logic [7:0] i2cByteReceived;
  logic       i2cComplete;

  modport master (
    output i2cInstruction,
    output i2cByteToSend,
    output i2cEnable,
    input  i2cByteReceived,
    input  i2cComplete
  );

  modport slave (
    input  i2cInstruction,
    input  i2cByteToSend,
    input  i2cEnable,
    output i2cByteReceived,
    output i2cComplete
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Runs single-byte I2C register writes/reads on the byte engine for N_REQ round-robin requesters.
module i2c_reg_sequencer #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [7*N_REQ-1:0]   req_dev,
  input  logic [8*N_REQ-1:0]   req_reg,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  i2c_reg_sequencer_if.master  i2c
);

  localparam int unsigned NU = N_REQ;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG, S_DATA,
    S_RSTART, S_DEV_R, S_READ, S_STOP, S_DONE
  } state_t;

  typedef enum logic { PH_ISSUE, PH_RELEASE } phase_t;

  state_t        state, stateNext, stepNext;
  phase_t        phase, phaseNext;
  logic [CW-1:0] stepCnt, stepCntNext;
  logic          abortQ, abortNext;

  logic [PW-1:0] rrPtr, grantQ, grantIdx;
  logic          grantValid, grantTake;
  logic          rwQ;
  logic [6:0]    devQ;
  logic [7:0]    regQ, wdataQ, rxByte;
  logic          inStep;

  // Round-robin search starting at rrPtr, wrapping.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (!grantValid && req[(32'(rrPtr) + i) % NU]) begin
        grantValid = 1'b1;
        grantIdx   = PW'((32'(rrPtr) + i) % NU);
      end
    end
  end

  // A grant waits out any completion still held by the engine so the first
  // enable never rises against a stale i2cComplete.
  assign grantTake = (state == S_IDLE) && grantValid && !i2c.i2cComplete;
  assign inStep    = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    stepNext = S_IDLE;
    unique case (state)
      S_START:  stepNext = S_DEV_W;
      S_DEV_W:  stepNext = S_REG;
      S_REG:    stepNext = rwQ ? S_RSTART : S_DATA;
      S_DATA:   stepNext = S_STOP;
      S_RSTART: stepNext = S_DEV_R;
      S_DEV_R:  stepNext = S_READ;
      S_READ:   stepNext = S_STOP;
      S_STOP:   stepNext = S_DONE;
      default:  stepNext = S_IDLE;
    endcase
  end

  always_comb begin
    stateNext   = state;
    phaseNext   = phase;
    stepCntNext = stepCnt;
    abortNext   = abortQ;
    unique case (state)
      S_IDLE: begin
        if (grantTake) begin
          stateNext   = S_START;
          phaseNext   = PH_ISSUE;
          stepCntNext = '0;
          abortNext   = 1'b0;
        end
      end
      S_DONE: stateNext = S_IDLE;
      default: begin
        if (stepCnt == CNT_LAST) begin
          stateNext = S_DONE;
          abortNext = 1'b1;
        end else begin
          stepCntNext = stepCnt + 1'b1;
          if (phase == PH_ISSUE) begin
            if (i2c.i2cComplete) phaseNext = PH_RELEASE;
          end else if (!i2c.i2cComplete) begin
            stateNext   = stepNext;
            phaseNext   = PH_ISSUE;
            stepCntNext = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= PH_ISSUE;
      stepCnt <= '0;
      abortQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      phase   <= phaseNext;
      stepCnt <= stepCntNext;
      abortQ  <= abortNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr  <= '0;
      grantQ <= '0;
      rwQ    <= 1'b0;
      devQ   <= '0;
      regQ   <= '0;
      wdataQ <= '0;
      rxByte <= '0;
      rdata  <= '0;
    end else begin
      if (grantTake) begin
        grantQ <= grantIdx;
        rrPtr  <= (32'(grantIdx) == NU - 1) ? '0 : grantIdx + 1'b1;
        rwQ    <= req_rw[grantIdx];
        devQ   <= req_dev[7*grantIdx +: 7];
        regQ   <= req_reg[8*grantIdx +: 8];
        wdataQ <= req_wdata[8*grantIdx +: 8];
      end
      if (state == S_READ && phase == PH_ISSUE && i2c.i2cComplete)
        rxByte <= i2c.i2cByteReceived;
      // rdata only moves on a successful read so it stays put across aborts.
      if (state == S_STOP && stateNext == S_DONE && !abortNext && rwQ)
        rdata <= rxByte;
    end
  end

  always_comb begin
    i2c.i2cInstruction = '0;
    i2c.i2cByteToSend  = '0;
    unique case (state)
      S_START, S_RSTART: i2c.i2cInstruction = OP_START;
      S_STOP:            i2c.i2cInstruction = OP_STOP;
      S_READ:            i2c.i2cInstruction = OP_READ;
      S_DEV_W: begin
        i2c.i2cInstruction = OP_WRITE;
        i2c.i2cByteToSend  = {devQ, 1'b0};
      end
      S_REG: begin
        i2c.i2cInstruction = OP_WRITE;
        i2c.i2cByteToSend  = regQ;
      end
      S_DATA: begin
        i2c.i2cInstruction = OP_WRITE;
        i2c.i2cByteToSend  = wdataQ;
      end
      S_DEV_R: begin
        i2c.i2cInstruction = OP_WRITE;
        i2c.i2cByteToSend  = {devQ, 1'b1};
      end
      default: ;
    endcase
  end

  assign i2c.i2cEnable = inStep && (phase == PH_ISSUE);
  assign busy          = inStep;
  assign err           = (state == S_DONE) && abortQ;

  always_comb begin
    done = '0;
    if (state == S_DONE) done[grantQ] = 1'b1;
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed + randomized bench for i2c_reg_sequencer with a behavioural byte-engine model.
module tb_i2c_reg_sequencer;
  localparam int N  = 2;
  localparam int TO = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0, reqRw = '0;
  logic [7*N-1:0] reqDev = '0;
  logic [8*N-1:0] reqReg = '0, reqWdata = '0;
  logic [N-1:0]   done;
  logic           err, busy;
  logic [7:0]     rdata;

  i2c_reg_sequencer_if eng ();

  i2c_reg_sequencer #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(reqRw), .req_dev(reqDev),
    .req_reg(reqReg), .req_wdata(reqWdata), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .i2c(eng)
  );

  always #5 clk = ~clk;

  int nCmp = 0, nErr = 0;
  int engLat = 0, engHold = 0;
  bit engStuck = 1'b0;
  logic [7:0] engRdata = '0;
  int violations = 0, unstable = 0, stallCycles = 0;
  logic [9:0] opsQ[$];
  logic [9:0] expQ[$];
  int rrRef = 0;
  logic [7:0] rdataRef = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine model: records each step it is handed, completes after engLat cycles,
  // holds complete for engHold cycles after enable drops, flags protocol breaks.
  initial begin : engine
    bit active, prevEn, stall;
    int cnt, holdCnt;
    logic [1:0] ci;
    logic [7:0] cb;
    active = 0; prevEn = 0; stall = 0; cnt = 0; holdCnt = 0; ci = '0; cb = '0;
    eng.i2cComplete = 1'b0;
    eng.i2cByteReceived = '0;
    forever begin
      tick();
      if (rst) begin
        eng.i2cComplete = 1'b0;
        active = 0; prevEn = 0; stall = 0; holdCnt = 0;
      end else begin
        if (eng.i2cEnable && !prevEn && eng.i2cComplete) violations++;
        prevEn = eng.i2cEnable;
        if (eng.i2cEnable) begin
          if (!active && !eng.i2cComplete) begin
            active = 1; ci = eng.i2cInstruction; cb = eng.i2cByteToSend; cnt = engLat;
            stall = engStuck && (ci == 2'b10);
            if (stall) engStuck = 1'b0;
            opsQ.push_back({ci, (ci == 2'b10) ? cb : 8'h00});
          end
          if (active) begin
            if (eng.i2cInstruction !== ci || eng.i2cByteToSend !== cb) unstable++;
            if (stall) stallCycles++;
            else if (cnt == 0) begin
              eng.i2cComplete = 1'b1;
              if (ci == 2'b11) eng.i2cByteReceived = engRdata;
              active = 0;
            end else cnt--;
          end
        end else begin
          active = 0; stall = 0;
          if (eng.i2cComplete) begin
            if (holdCnt >= engHold) begin eng.i2cComplete = 1'b0; holdCnt = 0; end
            else holdCnt++;
          end
        end
      end
    end
  end

  task automatic addExp(input bit rw, input logic [6:0] d, input logic [7:0] rg, input logic [7:0] wd);
    expQ.push_back({2'b00, 8'h00});
    expQ.push_back({2'b10, d, 1'b0});
    expQ.push_back({2'b10, rg});
    if (rw) begin
      expQ.push_back({2'b00, 8'h00});
      expQ.push_back({2'b10, d, 1'b1});
      expQ.push_back({2'b11, 8'h00});
    end else begin
      expQ.push_back({2'b10, wd});
    end
    expQ.push_back({2'b01, 8'h00});
  endtask

  task automatic compareOps(input string tag);
    check($sformatf("%s opcount", tag), opsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < opsQ.size(); i++)
      check($sformatf("%s op%0d", tag, i), opsQ[i], expQ[i]);
  endtask

  function automatic int pickNext(input logic [N-1:0] r, input int rr);
    for (int j = 0; j < N; j++)
      if (r[(rr + j) % N]) return (rr + j) % N;
    return -1;
  endfunction

  task automatic runTxn(input string tag, input int idx, input bit rw, input logic [6:0] d,
                        input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rd,
                        input int lat, input int hold, input bit stuck, input int expTicks);
    int t;
    bit seen, scrambled;
    logic [N-1:0] dv;
    logic ev, bv;
    logic [7:0] rv;
    engLat = lat; engHold = hold; engStuck = stuck; engRdata = rd; stallCycles = 0;
    opsQ.delete(); expQ.delete();
    if (stuck) begin
      expQ.push_back({2'b00, 8'h00});
      expQ.push_back({2'b10, d, 1'b0});
    end else addExp(rw, d, rg, wd);
    reqRw[idx] = rw; reqDev[7*idx +: 7] = d; reqReg[8*idx +: 8] = rg; reqWdata[8*idx +: 8] = wd;
    req[idx] = 1'b1;
    seen = 0; scrambled = 0; t = 0; dv = 'x; ev = 1'bx; bv = 1'bx; rv = 'x;
    while (!seen && t < 1000) begin
      tick(); t++;
      if (busy && !scrambled) begin
        scrambled = 1;
        reqRw[idx] = ~rw; reqDev[7*idx +: 7] = ~d; reqReg[8*idx +: 8] = ~rg; reqWdata[8*idx +: 8] = ~wd;
      end
      if (done != '0) begin seen = 1; dv = done; ev = err; bv = busy; rv = rdata; end
    end
    req[idx] = 1'b0;
    check($sformatf("%s done seen", tag), seen, 1);
    check($sformatf("%s done vector", tag), dv, 32'(1 << idx));
    check($sformatf("%s err", tag), ev, stuck);
    check($sformatf("%s busy at done", tag), bv, 0);
    if (rw && !stuck) rdataRef = rd;
    if (rw || stuck) check($sformatf("%s rdata", tag), rv, rdataRef);
    if (expTicks > 0) check($sformatf("%s latency", tag), t, expTicks);
    if (stuck) check($sformatf("%s timeout cycles", tag), stallCycles, TO);
    compareOps(tag);
    tick();
    check($sformatf("%s done after", tag), done, 0);
    check($sformatf("%s err after", tag), err, 0);
    check($sformatf("%s busy after", tag), busy, 0);
    rrRef = (idx + 1) % N;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int idx, t, nd, rr, g;
    bit rw, reached;
    logic [6:0] d;
    logic [7:0] rg, wd, rd;
    int grants[$];
    bit fRw[N];
    logic [6:0] fDev[N];
    logic [7:0] fReg[N], fWd[N];

    repeat (3) tick();
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst busy", busy, 0);
    check("rst rdata", rdata, 0);
    check("rst enable", eng.i2cEnable, 0);
    check("rst instr", eng.i2cInstruction, 0);
    check("rst byte", eng.i2cByteToSend, 0);
    rst = 1'b0;
    tick();
    check("idle busy", busy, 0);
    check("idle enable", eng.i2cEnable, 0);

    runTxn("write", 0, 0, 7'h48, 8'h01, 8'hC3, 8'h00, 0, 0, 0, 11);
    runTxn("read", 1, 1, 7'h48, 8'h00, 8'h00, 8'h5A, 0, 0, 0, 15);

    for (int k = 0; k < 10; k++) begin
      idx = $urandom_range(0, N-1);
      rw  = 1'($urandom_range(0, 1));
      d = 7'($urandom); rg = 8'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      runTxn($sformatf("rnd%0d", k), idx, rw, d, rg, wd, rd,
             $urandom_range(0, 4), $urandom_range(0, 3), 0, 0);
    end

    // Both requesters held high for 8 transactions.
    opsQ.delete(); expQ.delete(); grants.delete();
    engLat = 1; engHold = 0; engRdata = 8'hA5;
    fRw[0] = 0; fDev[0] = 7'h2C; fReg[0] = 8'h20; fWd[0] = 8'h66;
    fRw[1] = 1; fDev[1] = 7'h33; fReg[1] = 8'h10; fWd[1] = 8'h77;
    for (int i = 0; i < N; i++) begin
      reqRw[i] = fRw[i]; reqDev[7*i +: 7] = fDev[i]; reqReg[8*i +: 8] = fReg[i]; reqWdata[8*i +: 8] = fWd[i];
    end
    req = '1;
    nd = 0; t = 0;
    while (nd < 8 && t < 4000) begin
      tick(); t++;
      if (done != '0) begin
        nd++;
        grants.push_back(done == 2'b01 ? 0 : (done == 2'b10 ? 1 : -1));
        check($sformatf("fair err %0d", nd), err, 0);
        if (done[1]) check($sformatf("fair rdata %0d", nd), rdata, 8'hA5);
        if (nd == 8) req = '0;
      end
    end
    req = '0;
    check("fair count", nd, 8);
    rr = rrRef;
    for (int k = 0; k < 8; k++) begin
      g = pickNext('1, rr);
      if (k < grants.size()) check($sformatf("fair grant %0d", k), grants[k], g);
      addExp(fRw[g], fDev[g], fReg[g], fWd[g]);
      rr = (g + 1) % N;
    end
    rrRef = rr;
    rdataRef = 8'hA5;
    compareOps("fair");
    tick();

    runTxn("timeout", 0, 0, 7'h1B, 8'h42, 8'h99, 8'h00, 0, 0, 1, 0);
    runTxn("postTimeout", 0, 1, 7'h48, 8'h07, 8'h00, 8'h3C, 1, 1, 0, 0);
    runTxn("hold", 1, 0, 7'h55, 8'hAA, 8'h0F, 8'h00, 1, 10, 0, 0);
    check("hold violations", violations, 0);

    // Reset while the READ step is pending at the engine.
    opsQ.delete();
    engLat = 20; engHold = 0;
    reqRw[0] = 1; reqDev[6:0] = 7'h50; reqReg[7:0] = 8'h04; req[0] = 1'b1;
    t = 0;
    while (!(eng.i2cEnable && eng.i2cInstruction == 2'b11) && t < 1000) begin tick(); t++; end
    reached = (eng.i2cEnable && eng.i2cInstruction == 2'b11);
    check("mid-read reached", reached, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst enable drop", eng.i2cEnable, 0);
    check("rst busy drop", busy, 0);
    check("rst done drop", done, 0);
    req[0] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    rrRef = 0; rdataRef = 8'h00;
    check("rst rdata cleared", rdata, 0);
    tick();
    runTxn("afterReset", 1, 0, 7'h48, 8'h01, 8'hC3, 8'h00, 0, 0, 0, 11);

    check("handshake violations", violations, 0);
    check("step stability", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
